// File: rtl/dec_stage.sv
// Registered valid/ready decode stage: class field split, register selects, immediate extension, illegal flag, PC tag.
// Latency 1 cycle. Define DEC_SKID_EN to add a one-entry skid buffer, which makes in_ready a registered signal.
module dec_stage #(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instruction,
  input  logic [PC_W-1:0] pc_i,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2:0]      class_o,
  output logic [1:0]      bc_o,
  output logic            ct_o,
  output logic [4:0]      opcode_o,
  output logic [4:0]      rd_addr,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] imm_o,
  output logic            rd_we,
  output logic            rs1_used,
  output logic            rs2_used,
  output logic            illegal_o,
  output logic [PC_W-1:0] pc_o
);

  typedef struct packed {
    logic [2:0]      cls;
    logic [4:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    logic            rd_we;
    logic            rs1_used;
    logic            rs2_used;
    logic            illegal;
    logic [PC_W-1:0] pc;
  } bundle_t;

  bundle_t dec;
  bundle_t out_q;
  logic    accept;
  logic    out_free;

  always_comb begin
    dec        = '0;
    dec.cls    = instruction[31:29];
    dec.opcode = instruction[28:24];
    dec.pc     = pc_i;
    case (instruction[31:29])
      3'b000: begin
        dec.rd       = instruction[23:19];
        dec.rs1      = instruction[18:14];
        dec.rs2      = instruction[13:9];
        dec.rd_we    = 1'b1;
        dec.rs1_used = 1'b1;
        dec.rs2_used = 1'b1;
      end
      3'b001, 3'b010: begin
        dec.rd       = instruction[23:19];
        dec.rs1      = instruction[18:14];
        dec.imm      = XLEN'($signed(instruction[13:0]));
        dec.rd_we    = 1'b1;
        dec.rs1_used = 1'b1;
      end
      3'b011, 3'b100: begin
        // Stores and branches put their second source where other classes keep rd.
        dec.rs1      = instruction[18:14];
        dec.rs2      = instruction[23:19];
        dec.imm      = XLEN'($signed(instruction[13:0]));
        dec.rs1_used = 1'b1;
        dec.rs2_used = 1'b1;
      end
      3'b101: begin
        dec.rd    = instruction[23:19];
        dec.imm   = XLEN'($signed(instruction[18:0]));
        dec.rd_we = 1'b1;
      end
      3'b110: dec.imm = XLEN'(instruction[18:0]);
      default: dec.illegal = 1'b1;
    endcase
  end

  assign accept   = in_valid & in_ready & ~flush;
  assign out_free = ~out_valid | out_ready;

`ifdef DEC_SKID_EN
  bundle_t skid_q;
  logic    skid_vld;

  assign in_ready = rst_n & ~skid_vld;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_q     <= '0;
      skid_vld  <= 1'b0;
      skid_q    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      skid_vld  <= 1'b0;
    end else if (skid_vld) begin
      // in_ready is low here, so nothing new arrives while the skid drains.
      if (out_ready) begin
        out_q    <= skid_q;
        skid_vld <= 1'b0;
      end
    end else if (out_free) begin
      out_valid <= accept;
      if (accept) out_q <= dec;
    end else if (accept) begin
      skid_q   <= dec;
      skid_vld <= 1'b1;
    end
  end
`else
  assign in_ready = rst_n & out_free;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_q     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (out_free) begin
      out_valid <= accept;
      if (accept) out_q <= dec;
    end
  end
`endif

  assign class_o   = out_q.cls;
  assign bc_o      = out_q.cls[2:1];
  assign ct_o      = out_q.cls[0];
  assign opcode_o  = out_q.opcode;
  assign rd_addr   = out_q.rd;
  assign rs1_addr  = out_q.rs1;
  assign rs2_addr  = out_q.rs2;
  assign imm_o     = out_q.imm;
  assign rd_we     = out_q.rd_we;
  assign rs1_used  = out_q.rs1_used;
  assign rs2_used  = out_q.rs2_used;
  assign illegal_o = out_q.illegal;
  assign pc_o      = out_q.pc;

endmodule
